gray_fifo_rd_ctrl: RTL
======================

# gray_fifo_rd_ctrl

Read-side pointer controller for the team's dual-clock FIFOs. It receives the write pointer from the write clock domain as Gray code and synchronizes it into the read clock. It converts that pointer to binary and maintains the local binary/Gray read pointer. From these it generates the RAM read address, empty/almost-empty flags and fill level. This block is the consuming end of the Gray-pointer handshake: the write side encodes, this block synchronizes and decodes.

## Interface
- ADDR_WIDTH, 3: RAM address width; depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- SYNC_STAGES, 2: flip-flop stages on wptr_gray (legal 2..4).
- AE_THRESH, 1: almost_empty asserts when level <= AE_THRESH.
- clk  in  1  read-domain clock.
- rst_n  in  1  reset, synchronous, active-low.
- wptr_gray  in  ADDR_WIDTH+1  write pointer, Gray coded, asynchronous to clk.
- rd_req  in  1  consumer read request.
- rd_en  out  1  accepted read, combinational = rd_req & ~empty; RAM read strobe.
- raddr  out  ADDR_WIDTH  RAM read address = rptr_bin[ADDR_WIDTH-1:0].
- rptr_gray  out  ADDR_WIDTH+1  registered Gray read pointer, to write domain.
- empty  out  1  registered empty flag.
- almost_empty  out  1  registered, level <= AE_THRESH.
- level  out  ADDR_WIDTH+1  registered fill count, 0..2^ADDR_WIDTH.
- gray_err  out  1  sticky synchronized-pointer error (see Configuration).

## Operation
- The sync chain is SYNC_STAGES registers on wptr_gray. wq_gray is the last stage. wq_bin is the Gray-to-binary conversion of wq_gray (bit i = XOR of bits i..MSB).
- rptr_bin_nxt = rptr_bin + rd_en, modulo 2^(ADDR_WIDTH+1). rptr_bin <= rptr_bin_nxt. rptr_gray <= rptr_bin_nxt ^ (rptr_bin_nxt >> 1).
- level <= wq_bin - rptr_bin_nxt, modulo 2^(ADDR_WIDTH+1). empty <= (level_nxt == 0), equivalently Gray equality of rptr_gray_nxt and wq_gray. almost_empty <= (level_nxt <= AE_THRESH).
- rd_req while empty: ignored. rd_en=0 and no pointer, level or flag change (underflow protection).
- Wrap-around: both pointers wrap from 2^(ADDR_WIDTH+1)-1 to 0. The extra MSB keeps level correct across the wrap.
- Simultaneous read and synchronized write increment on the same edge: level is unchanged and empty is unchanged.
- This block has no full flag; the write side owns overflow.
- Reset (synchronous, any time, including mid-burst): on the next edge all sync stages, rptr_bin, rptr_gray, raddr, level and gray_err go to 0; empty and almost_empty go to 1. While rst_n=0, rd_en=0.

## Timing
- A wptr_gray change at the input reaches wq_gray after SYNC_STAGES edges. It is reflected in level/empty on the following edge, so SYNC_STAGES+1 edges total.
- Read: rd_en is high in the same cycle as rd_req, and raddr is valid in that cycle. On that edge rptr_bin, rptr_gray, level and empty update. RAM data is the consumer's concern, one cycle later for a registered RAM.
- Back-to-back reads: one per cycle while empty=0. The read that drains the last word asserts empty on its edge.
- rptr_gray changes by exactly one bit per read, with no glitches (registered output).

## Configuration
- GRAY_CHECK_EN defined:
  - Registers the previous wq_gray.
  - Sets gray_err when consecutive wq_gray values differ in more than one bit, or when wq_bin - rptr_bin exceeds 2^ADDR_WIDTH.
  - gray_err asserts on the edge after detection, stays high until reset, and does not alter pointer behaviour.
- GRAY_CHECK_EN undefined: the check logic is absent and gray_err is tied to 0.

## Test plan
All scenarios use ADDR_WIDTH=3 and SYNC_STAGES=2.
- Reset: hold rst_n=0 for one edge with wptr_gray=0101 -> empty=1, almost_empty=1, level=0, rptr_gray=0000, raddr=0, rd_en=0 while in reset.
- Latency: wptr_gray 0000->0001 -> empty stays 1 for 2 edges, clears on the 3rd edge, level=1, almost_empty=1.
- Drain full: wptr_gray=1100 (bin 8) settled, so level=8. Hold rd_req=1 for 9 cycles -> raddr 0..7. rptr_gray steps 0001,0011,0010,0110,0111,0101,0100,1100. empty asserts on the 8th edge. The 9th cycle has rd_en=0 and the pointer holds.
- Wrap: rptr_bin=14 (gray 1001), wptr_gray stepped 1001->1000->0000->0001 (bin 1) -> level=3. Three reads -> rptr_gray 1000,0000,0001, then empty=1.
- Simultaneous: level=1, read accepted on the same edge as the synchronized wptr increment -> level stays 1, empty stays 0.
- Error check, macro defined: synchronized wptr_gray jumps 0000->0011 -> gray_err=1 three edges after the input change. It stays 1 until rst_n=0. With the macro undefined, gray_err stays 0.

Source files
------------

// File: rtl/gray_fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// gray_fifo_rd_ctrl
//
// Read-side pointer controller for a dual-clock FIFO. The write pointer arrives
// from the write clock domain in Gray code. It is synchronized into clk and
// decoded to binary. The block keeps the local binary and Gray read pointers.
// From these it produces the RAM read strobe and address, the registered
// empty and almost-empty flags, and the fill level.
//
// Optional feature: define GRAY_CHECK_EN to build the synchronized-pointer
// sanity check that drives gray_err. Without the macro, gray_err is tied to 0.
//
// Parameters
//   ADDR_WIDTH   RAM address width; depth = 2**ADDR_WIDTH; pointers are
//                ADDR_WIDTH+1 bits wide.
//   SYNC_STAGES  Number of flops in the wptr_gray synchronizer (2..4).
//   AE_THRESH    almost_empty asserts when level <= AE_THRESH.
//
// Ports
//   clk           in   read-domain clock
//   rst_n         in   synchronous, active-low reset
//   wptr_gray     in   write pointer, Gray coded, asynchronous to clk
//   rd_req        in   consumer read request
//   rd_en         out  accepted read (rd_req & ~empty), RAM read strobe
//   raddr         out  RAM read address (low bits of the binary read pointer)
//   rptr_gray     out  registered Gray read pointer, sent to the write domain
//   empty         out  registered empty flag
//   almost_empty  out  registered, level <= AE_THRESH
//   level         out  registered fill count, 0..2**ADDR_WIDTH
//   gray_err      out  sticky synchronized-pointer error
// -----------------------------------------------------------------------------
module gray_fifo_rd_ctrl #(
  parameter int ADDR_WIDTH  = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH:0]   wptr_gray,
  input  logic                  rd_req,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [ADDR_WIDTH:0]   rptr_gray,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  gray_err
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);
  localparam logic [PW-1:0] DEPTH  = {1'b1, {ADDR_WIDTH{1'b0}}};

  // Gray to binary: bit i is the XOR of Gray bits i..MSB.
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Synchronizer chain, stage 0 samples the asynchronous input.
  logic [SYNC_STAGES-1:0][PW-1:0] sync_q;

  logic [PW-1:0] rptr_bin_q, rptr_bin_d;
  logic [PW-1:0] rptr_gray_q, rptr_gray_d;
  logic [PW-1:0] level_q, level_d;
  logic          empty_q, empty_d;
  logic          ae_q, ae_d;

  logic [PW-1:0] wq_gray;
  logic [PW-1:0] wq_bin;

  assign wq_gray = sync_q[SYNC_STAGES-1];
  assign wq_bin  = gray2bin(wq_gray);

  // Reads are refused while empty (underflow protection) and during reset.
  assign rd_en = rd_req & ~empty_q & rst_n;

  always_comb begin
    rptr_bin_d  = rptr_bin_q + {{ADDR_WIDTH{1'b0}}, rd_en};
    rptr_gray_d = bin2gray(rptr_bin_d);
    // The extra pointer MSB keeps this subtraction correct across wrap.
    level_d     = wq_bin - rptr_bin_d;
    empty_d     = (level_d == '0);
    ae_d        = (level_d <= AE_LVL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q      <= '0;
      rptr_bin_q  <= '0;
      rptr_gray_q <= '0;
      level_q     <= '0;
      empty_q     <= 1'b1;
      ae_q        <= 1'b1;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], wptr_gray};
      rptr_bin_q  <= rptr_bin_d;
      rptr_gray_q <= rptr_gray_d;
      level_q     <= level_d;
      empty_q     <= empty_d;
      ae_q        <= ae_d;
    end
  end

  assign raddr        = rptr_bin_q[ADDR_WIDTH-1:0];
  assign rptr_gray    = rptr_gray_q;
  assign level        = level_q;
  assign empty        = empty_q;
  assign almost_empty = ae_q;

`ifdef GRAY_CHECK_EN
  logic [PW-1:0] wq_prev_q;
  logic          err_q;
  logic [PW-1:0] wq_diff;
  logic [PW-1:0] wq_span;
  logic          err_hit;

  // A legal synchronized Gray pointer moves by at most one bit per cycle and
  // can never be more than one FIFO depth ahead of the read pointer.
  always_comb begin
    wq_diff = wq_prev_q ^ wq_gray;
    wq_span = wq_bin - rptr_bin_q;
    err_hit = ((wq_diff & (wq_diff - 1'b1)) != '0) | (wq_span > DEPTH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wq_prev_q <= '0;
      err_q     <= 1'b0;
    end else begin
      wq_prev_q <= wq_gray;
      err_q     <= err_q | err_hit;
    end
  end

  assign gray_err = err_q;
`else
  assign gray_err = 1'b0;
`endif

endmodule
